// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the uart_xcvr transceiver.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // True when the parameter set describes a buildable transceiver.
    function automatic bit params_legal(input int unsigned clk_freq,
                                        input int unsigned baud_rate,
                                        input int unsigned data_bits,
                                        input int unsigned stop_bits,
                                        input int unsigned tx_depth,
                                        input int unsigned parity_odd);
        if (baud_rate == 0) return 1'b0;
        if ((clk_freq % baud_rate) != 0) return 1'b0;
        if (clks_per_bit(clk_freq, baud_rate) < 4) return 1'b0;
        if (data_bits < 5 || data_bits > 8) return 1'b0;
        if (stop_bits < 1 || stop_bits > 2) return 1'b0;
        if (tx_depth < 2 || (tx_depth & (tx_depth - 1)) != 0) return 1'b0;
        if (parity_odd > 1) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO buffering host bytes ahead of the UART transmitter.
module uart_fifo
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rd_data_c = mem_q[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with TX FIFO and RX error reporting.
// Define UART_PARITY_EN to add a parity bit to both directions.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 1000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned PARITY_ODD = 0
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 newd,
    input  logic [DATA_BITS-1:0] dintx,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx,
    output logic                 donetx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] doutrx,
    output logic                 donerx,
    output logic                 rx_ferr,
    output logic                 rx_perr
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned HALF  = CPB / 2;
    localparam int unsigned CW    = $clog2(TX_DEPTH) + 1;

    if (!params_legal(CLK_FREQ, BAUD_RATE, DATA_BITS, STOP_BITS, TX_DEPTH, PARITY_ODD)) begin : g_bad_params
        $error("uart_xcvr: illegal parameter set");
    end

    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full_unused;
    logic [CW-1:0]        fifo_count;
    logic [DATA_BITS-1:0] fifo_rd_data;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (newd),
        .pop       (fifo_pop),
        .wr_data   (dintx),
        .rd_data_c (fifo_rd_data),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_q, tx_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 donetx_q, donetx_d;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CNT_W'(1);
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        fifo_pop   = 1'b0;
        tx_bit_end = (tx_cnt_q == CNT_W'(CPB - 1));
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_bit_end) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_cnt_d = '0;
                tx_sh_d  = tx_sh_q >> 1;
                if (tx_idx_q == 3'(DATA_BITS - 1)) begin
                    tx_idx_d = '0;
`ifdef UART_PARITY_EN
                    tx_state_d = TX_PARITY;
`else
                    tx_state_d = TX_STOP;
`endif
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: if (tx_bit_end) begin
                tx_cnt_d   = '0;
                tx_state_d = TX_STOP;
            end
`endif
            // Back-to-back frames: the next start bit follows the last stop clock directly.
            TX_STOP: if (tx_bit_end) begin
                tx_cnt_d = '0;
                if (tx_idx_q == 3'(STOP_BITS - 1)) begin
                    tx_idx_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (fifo_pop) begin
            tx_sh_d  = fifo_rd_data;
            tx_cnt_d = '0;
            tx_idx_d = '0;
`ifdef UART_PARITY_EN
            tx_par_d = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
        end

        // Line level follows the state being entered so tx stays aligned with the FSM.
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_sh_d[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_d = tx_par_d;
`endif
            default:   tx_d = 1'b1;
        endcase

        tx_busy_d = (tx_state_d != TX_IDLE);
        donetx_d  = (tx_state_d == TX_STOP) && (tx_cnt_d == CNT_W'(CPB - 1))
                    && (tx_idx_d == 3'(STOP_BITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            donetx_q   <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            donetx_q   <= donetx_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    // ---------------- receiver ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic [1:0]           sync_q, sync_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_armed_q, rx_armed_d;
    logic [DATA_BITS-1:0] doutrx_q, doutrx_d;
    logic                 donerx_q, donerx_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_s;
    logic                 rx_bit_end;
`ifdef UART_PARITY_EN
    logic                 rx_pbad_q, rx_pbad_d;
    logic                 rx_perr_q, rx_perr_d;
`endif

    always_comb begin
        sync_d     = {sync_q[0], rx};
        rx_s       = sync_q[1];
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_armed_d = rx_armed_q;
        doutrx_d   = doutrx_q;
        donerx_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        rx_bit_end = (rx_cnt_q == CNT_W'(CPB - 1));
`ifdef UART_PARITY_EN
        rx_pbad_d  = rx_pbad_q;
        rx_perr_d  = 1'b0;
`endif
        case (rx_state_q)
            // Only a falling edge after an observed idle-high line starts a frame.
            RX_IDLE: begin
                rx_cnt_d   = '0;
                rx_armed_d = rx_armed_q | rx_s;
                if (rx_armed_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_armed_d = 1'b0;
                end
            end
            RX_START: if (rx_cnt_q == CNT_W'(HALF - 1)) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_bit_end) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                if (rx_idx_q == 3'(DATA_BITS - 1)) begin
                    rx_idx_d = '0;
`ifdef UART_PARITY_EN
                    rx_state_d = RX_PARITY;
`else
                    rx_state_d = RX_STOP;
`endif
                end else begin
                    rx_idx_d = rx_idx_q + 3'd1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_pbad_d  = rx_s ^ (^rx_sh_q) ^ 1'(PARITY_ODD);
                rx_state_d = RX_STOP;
            end
`endif
            RX_STOP: if (rx_bit_end) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
                rx_ferr_d  = !rx_s;
`ifdef UART_PARITY_EN
                rx_perr_d  = rx_pbad_q;
                if (rx_s && !rx_pbad_q) begin
`else
                if (rx_s) begin
`endif
                    donerx_d = 1'b1;
                    doutrx_d = rx_sh_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_sh_q    <= '0;
            rx_armed_q <= 1'b0;
            doutrx_q   <= '0;
            donerx_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pbad_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
            rx_armed_q <= rx_armed_d;
            doutrx_q   <= doutrx_d;
            donerx_q   <= donerx_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_pbad_q  <= rx_pbad_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    assign tx_ready = (fifo_count != CW'(TX_DEPTH));
    assign tx_busy  = tx_busy_q;
    assign tx       = tx_q;
    assign donetx   = donetx_q;
    assign doutrx   = doutrx_q;
    assign donerx   = donerx_q;
    assign rx_ferr  = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_perr  = rx_perr_q;
`else
    assign rx_perr  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed self-checking bench for uart_xcvr at 10 clocks per bit.
module tb_uart_xcvr;

    localparam int unsigned CPB  = 10;
`ifdef UART_PARITY_EN
    localparam int unsigned FL   = 11;
`else
    localparam int unsigned FL   = 10;
`endif
    localparam int unsigned FCLK = FL * CPB;

    logic       clk;
    logic       rst;
    logic       newd;
    logic [7:0] dintx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx;
    logic       donetx;
    logic       rx;
    logic [7:0] doutrx;
    logic       donerx;
    logic       rx_ferr;
    logic       rx_perr;

    logic       loop_en;
    logic       rx_drv;
    logic       seen_done;
    logic       seen_ferr;
    logic       seen_perr;
    logic [7:0] tx_exp [5];
    int         errors;
    int         checks;
    bit         found;

    assign rx = loop_en ? tx : rx_drv;

    uart_xcvr #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (100000),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .TX_DEPTH   (4),
        .PARITY_ODD (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .newd     (newd),
        .dintx    (dintx),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx       (tx),
        .donetx   (donetx),
        .rx       (rx),
        .doutrx   (doutrx),
        .donerx   (donerx),
        .rx_ferr  (rx_ferr),
        .rx_perr  (rx_perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level of bit j of a frame carrying d (start, LSB-first data, [even parity], stop).
    function automatic logic tx_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
`ifdef UART_PARITY_EN
        if (j == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_seen();
        seen_done = 1'b0;
        seen_ferr = 1'b0;
        seen_perr = 1'b0;
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge clk);
            if (donerx === 1'b1) seen_done = 1'b1;
            if (rx_ferr === 1'b1) seen_ferr = 1'b1;
            if (rx_perr === 1'b1) seen_perr = 1'b1;
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        newd  = 1'b1;
        dintx = d;
        @(negedge clk);
        newd  = 1'b0;
    endtask

    // Called at frame clock 'off' of the first frame; checks every clock of nf frames.
    task automatic check_tx(input int nf, input int off, input string tag);
        for (int i = off; i < nf * int'(FCLK); i++) begin
            int f;
            int j;
            f = i / int'(FCLK);
            j = (i % int'(FCLK)) / int'(CPB);
            chk(tag, 32'(tx), 32'(tx_bit(tx_exp[f], j)));
            chk({tag, "_donetx"}, 32'(donetx), 32'((i % int'(FCLK)) == int'(FCLK) - 1));
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic flip);
        logic b;
        for (int j = 0; j < int'(FL); j++) begin
            b = tx_bit(d, j);
            if (j == int'(FL) - 1) b = stop_v;
            if (j == 9 && FL == 11) b = b ^ flip;
            rx_drv = b;
            watch(int'(CPB));
        end
        rx_drv = 1'b1;
        watch(20);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst     = 1'b1;
        newd    = 1'b0;
        dintx   = 8'h00;
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        found   = 1'b0;
        clear_seen();
        repeat (3) @(negedge clk);

        chk("rst_tx",       32'(tx),       32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_tx_busy",  32'(tx_busy),  32'd0);
        chk("rst_donetx",   32'(donetx),   32'd0);
        chk("rst_doutrx",   32'(doutrx),   32'h00);
        chk("rst_donerx",   32'(donerx),   32'd0);
        chk("rst_rx_ferr",  32'(rx_ferr),  32'd0);
        chk("rst_rx_perr",  32'(rx_perr),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame 0xA5, start bit one clock after the pop.
        push_one(8'hA5);
        chk("a5_latency", 32'(tx), 32'd1);
        @(negedge clk);
        tx_exp[0] = 8'hA5;
        check_tx(1, 0, "a5");
        chk("a5_idle_busy", 32'(tx_busy), 32'd0);

        // Six consecutive writes: one drains immediately, four fill, sixth dropped.
        for (int k = 0; k < 6; k++) begin
            chk("fill_ready", 32'(tx_ready), 32'(k < 5));
            chk("fill_tx",    32'(tx),       32'(k < 2));
            newd  = 1'b1;
            dintx = 8'(8'h11 * (k + 1));
            if (k < 5) tx_exp[k] = dintx;
            @(negedge clk);
        end
        newd = 1'b0;
        check_tx(5, 4, "burst");
        chk("burst_end_tx",   32'(tx),      32'd1);
        chk("burst_end_busy", 32'(tx_busy), 32'd0);
        repeat (FCLK) @(negedge clk);
        chk("burst_no_sixth", 32'(tx_busy), 32'd0);

        // Loopback of 0x3C.
        loop_en = 1'b1;
        push_one(8'h3C);
        found = 1'b0;
        for (int i = 0; i < int'(FCLK) + 40 && !found; i++) begin
            @(negedge clk);
            found = (donerx === 1'b1);
        end
        chk("loop_donerx", 32'(found),   32'd1);
        chk("loop_doutrx", 32'(doutrx),  32'h3C);
        chk("loop_ferr",   32'(rx_ferr), 32'd0);
        chk("loop_perr",   32'(rx_perr), 32'd0);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;

        // Three-clock glitch is rejected as a false start.
        clear_seen();
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        watch(30);
        chk("false_start", 32'({seen_done, seen_ferr, seen_perr}), 32'd0);

        clear_seen();
        send_frame(8'h81, 1'b1, 1'b0);
        chk("rx81_done",   32'(seen_done), 32'd1);
        chk("rx81_doutrx", 32'(doutrx),    32'h81);
        chk("rx81_ferr",   32'(seen_ferr), 32'd0);
        chk("rx81_perr",   32'(seen_perr), 32'd0);

        // Stop bit forced low: framing error, data held.
        clear_seen();
        send_frame(8'h55, 1'b0, 1'b0);
        chk("ferr_pulse",  32'(seen_ferr), 32'd1);
        chk("ferr_done",   32'(seen_done), 32'd0);
        chk("ferr_doutrx", 32'(doutrx),    32'h81);

        // Reset in the middle of a TX frame.
        push_one(8'hF0);
        repeat (25) @(negedge clk);
        chk("mid_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx",     32'(tx),       32'd1);
        chk("mid_rst_busy",   32'(tx_busy),  32'd0);
        chk("mid_rst_ready",  32'(tx_ready), 32'd1);
        chk("mid_rst_doutrx", 32'(doutrx),   32'h00);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("mid_after_tx",   32'(tx),      32'd1);
        chk("mid_after_busy", 32'(tx_busy), 32'd0);

`ifdef UART_PARITY_EN
        // 0x07 has three ones: even parity bit is 1.
        push_one(8'h07);
        repeat (1 + 9 * CPB + 5) @(negedge clk);
        chk("par_bit", 32'(tx), 32'd1);
        repeat (30) @(negedge clk);

        clear_seen();
        send_frame(8'h07, 1'b1, 1'b1);
        chk("perr_pulse", 32'(seen_perr), 32'd1);
        chk("perr_done",  32'(seen_done), 32'd0);
        chk("perr_ferr",  32'(seen_ferr), 32'd0);

        clear_seen();
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_ok_done",   32'(seen_done), 32'd1);
        chk("par_ok_doutrx", 32'(doutrx),    32'h07);
        chk("par_ok_perr",   32'(seen_perr), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
